// File: rtl/pio_pattern_sequencer.sv
// Avalon-MM output PIO with an autonomous pattern engine: static, rotate-left,
// rotate-right or blink, stepped every PERIOD+1 cycles, optional bounded run with irq.
module pio_pattern_sequencer #(
   parameter int                      DATA_WIDTH   = 8,
   parameter int                      PERIOD_WIDTH = 24,
   parameter logic [PERIOD_WIDTH-1:0] RESET_PERIOD = 24'd4999999
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  irq
);

   // state | meaning
   // IDLE  | pattern holds; waiting for a run write with a stepping mode
   // RUN   | period counter active, pattern steps on terminal count
   // DONE  | bounded sequence finished; done_flag raised, waits for CTRL write
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state, state_next;
   logic [DATA_WIDTH-1:0]   data_reg, pattern, stepped;
   logic                    run, irq_en, done_flag;
   logic [1:0]              mode;
   logic [7:0]              limit, step_cnt, step_inc;
   logic [PERIOD_WIDTH-1:0] period, cnt;
   logic                    wr, data_wr, ctrl_wr, period_wr, status_wr;
   logic                    do_step, restart, finish;
   logic                    unused_wd;

   assign wr        = chipselect && !write_n;
   assign data_wr   = wr && (address == 2'd0);
   assign ctrl_wr   = wr && (address == 2'd1);
   assign period_wr = wr && (address == 2'd2);
   assign status_wr = wr && (address == 2'd3);
   assign step_inc  = step_cnt + 8'd1;
   // writedata bits not mapped to any register field
   assign unused_wd = ^writedata;

   always_comb begin
      case (mode)
         2'd1:    stepped = {pattern[DATA_WIDTH-2:0], pattern[DATA_WIDTH-1]};
         2'd2:    stepped = {pattern[0], pattern[DATA_WIDTH-1:1]};
         2'd3:    stepped = pattern ^ data_reg;
         default: stepped = pattern;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // A CTRL write always takes priority over a terminal-count step on the same edge
   always_comb begin
      state_next = state;
      do_step    = 1'b0;
      restart    = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl_wr && writedata[0] && (writedata[2:1] != 2'd0)) begin
               restart    = 1'b1;
               state_next = RUN;
            end
         end
         RUN, DONE: begin
            if (ctrl_wr) begin
               if (writedata[0]) begin
                  restart    = 1'b1;
                  state_next = (writedata[2:1] != 2'd0) ? RUN : IDLE;
               end else begin
                  state_next = IDLE;
               end
            end else if (state == RUN && cnt == '0) begin
               do_step = 1'b1;
               if (limit != 8'd0 && step_inc == limit) begin
                  finish     = 1'b1;
                  state_next = DONE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg  <= '0;
         pattern   <= '0;
         run       <= 1'b0;
         mode      <= 2'd0;
         irq_en    <= 1'b0;
         limit     <= 8'd0;
         period    <= RESET_PERIOD;
         cnt       <= '0;
         step_cnt  <= 8'd0;
         done_flag <= 1'b0;
      end else begin
         if (data_wr) begin
            data_reg <= writedata[DATA_WIDTH-1:0];
            pattern  <= writedata[DATA_WIDTH-1:0];
         end else if (do_step) begin
            pattern <= stepped;
         end

         if (ctrl_wr) begin
            run    <= writedata[0];
            mode   <= writedata[2:1];
            irq_en <= writedata[3];
            limit  <= writedata[15:8];
         end else if (finish) begin
            run <= 1'b0;
         end

         if (period_wr) period <= writedata[PERIOD_WIDTH-1:0];

         if (restart)                        cnt <= period;
         else if (state == RUN && cnt == '0) cnt <= period;
         else if (state == RUN)              cnt <= cnt - 1'b1;

         if (restart)      step_cnt <= 8'd0;
         else if (do_step) step_cnt <= step_inc;

         if (finish)                         done_flag <= 1'b1;
         else if (restart)                   done_flag <= 1'b0;
         else if (status_wr && writedata[1]) done_flag <= 1'b0;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         2'd0: readdata = {{(32-DATA_WIDTH){1'b0}}, data_reg};
         2'd1: readdata = {16'd0, limit, 4'd0, irq_en, mode, run};
         2'd2: readdata = {{(32-PERIOD_WIDTH){1'b0}}, period};
         2'd3: readdata = {16'd0, step_cnt, 6'd0, done_flag, (state == RUN)};
         default: readdata = '0;
      endcase
   end

   assign out_port = pattern;
   assign irq      = done_flag && irq_en;

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Bench for pio_pattern_sequencer: cycle-timeline model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pio_pattern_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic [7:0]  out_port;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   pio_pattern_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: programmer's view of the registers plus the absolute cycle of the next step.
   logic [7:0]  m_data, m_pat, m_limit, m_steps;
   logic        m_run, m_irqen, m_busy, m_indone, m_done;
   logic [1:0]  m_mode;
   logic [23:0] m_period;
   int          cyc, m_next;

   always @(posedge clk or negedge reset_n) begin : model
      logic [7:0]  p, s;
      logic        bw, fin, cw;
      logic [31:0] wd;
      if (!reset_n) begin
         m_data <= 8'd0; m_pat <= 8'd0; m_limit <= 8'd0; m_steps <= 8'd0;
         m_run <= 1'b0; m_irqen <= 1'b0; m_busy <= 1'b0; m_indone <= 1'b0;
         m_done <= 1'b0; m_mode <= 2'd0; m_period <= 24'd4999999;
         cyc <= 0; m_next <= 0;
      end else begin
         bw  = chipselect && !write_n;
         cw  = bw && (address == 2'd1);
         wd  = writedata;
         p   = m_pat;
         s   = m_steps;
         fin = 1'b0;
         cyc <= cyc + 1;
         if (m_busy && !cw && cyc == m_next) begin
            case (m_mode)
               2'd1: p = 8'(((32'(m_pat) << 1) | (32'(m_pat) >> 7)) & 32'hFF);
               2'd2: p = 8'(((32'(m_pat) >> 1) | (32'(m_pat) << 7)) & 32'hFF);
               2'd3: p = m_pat ^ m_data;
               default: p = m_pat;
            endcase
            s = 8'((32'(m_steps) + 1) % 256);
            m_next <= cyc + int'(m_period) + 1;
            if (m_limit != 8'd0 && s == m_limit) fin = 1'b1;
         end
         m_pat <= (bw && address == 2'd0) ? wd[7:0] : p;
         if (bw && address == 2'd0) m_data <= wd[7:0];
         if (bw && address == 2'd2) m_period <= wd[23:0];
         if (cw) begin
            m_run <= wd[0]; m_mode <= wd[2:1]; m_irqen <= wd[3]; m_limit <= wd[15:8];
            if (wd[0] && (wd[2:1] != 2'd0 || m_busy || m_indone)) begin
               m_steps <= 8'd0; m_done <= 1'b0; m_indone <= 1'b0;
               m_busy <= (wd[2:1] != 2'd0);
               m_next <= cyc + int'(m_period) + 1;
            end else if (!wd[0]) begin
               m_busy <= 1'b0; m_indone <= 1'b0;
            end
         end else begin
            m_steps <= s;
            if (fin) begin
               m_busy <= 1'b0; m_indone <= 1'b1; m_run <= 1'b0; m_done <= 1'b1;
            end else if (bw && address == 2'd3 && wd[1]) begin
               m_done <= 1'b0;
            end
         end
      end
   end

   function automatic logic [31:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0:    return {24'd0, m_data};
         2'd1:    return {16'd0, m_limit, 4'd0, m_irqen, m_mode, m_run};
         2'd2:    return {8'd0, m_period};
         default: return {16'd0, m_steps, 6'd0, m_done, m_busy};
      endcase
   endfunction

   always @(negedge clk) begin
      chk("model out_port", {24'd0, out_port}, {24'd0, m_pat});
      chk("model irq", {31'd0, irq}, {31'd0, m_done && m_irqen});
      chk("model readdata", readdata, model_rd(address));
   end

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #2;
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a; #1;
      d = readdata;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [31:0] r;

   initial begin
      #1 reset_n = 1'b0;
      #1;
      chk("reset out_port", {24'd0, out_port}, 32'h0);
      chk("reset irq", {31'd0, irq}, 32'h0);
      rd(2'd3, r); chk("reset status", r, 32'h0);
      rd(2'd1, r); chk("reset ctrl", r, 32'h0);
      rd(2'd2, r); chk("reset period", r, 32'h004C4B3F);
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;

      // static output
      bus_write(2'd0, 32'hA5);
      chk("static out", {24'd0, out_port}, 32'hA5);
      rd(2'd0, r); chk("static data rd", r, 32'h000000A5);
      bus_write(2'd1, 32'h1);
      rd(2'd3, r); chk("static not busy", r, 32'h0);
      chk("static out hold", {24'd0, out_port}, 32'hA5);
      wait_cyc(3);
      chk("static out hold2", {24'd0, out_port}, 32'hA5);

      // rotate left, unbounded
      bus_write(2'd0, 32'h81);
      bus_write(2'd2, 32'd3);
      bus_write(2'd1, 32'h0003);
      wait_cyc(4); chk("rotl step1", {24'd0, out_port}, 32'h03);
      wait_cyc(4); chk("rotl step2", {24'd0, out_port}, 32'h06);
      wait_cyc(4); chk("rotl step3", {24'd0, out_port}, 32'h0C);
      rd(2'd3, r); chk("rotl status", r, 32'h0301);
      bus_write(2'd1, 32'h0002);
      wait_cyc(6); chk("rotl stopped", {24'd0, out_port}, 32'h0C);

      // bounded blink with interrupt
      bus_write(2'd0, 32'h0F);
      bus_write(2'd2, 32'd1);
      bus_write(2'd1, 32'h040F);
      wait_cyc(2); chk("blink step1", {24'd0, out_port}, 32'h00);
      wait_cyc(2); chk("blink step2", {24'd0, out_port}, 32'h0F);
      wait_cyc(2); chk("blink step3", {24'd0, out_port}, 32'h00);
      wait_cyc(2); chk("blink step4", {24'd0, out_port}, 32'h0F);
      rd(2'd3, r); chk("blink done status", r, 32'h0402);
      chk("blink irq", {31'd0, irq}, 32'h1);
      rd(2'd1, r); chk("blink ctrl run cleared", r, 32'h040E);
      wait_cyc(4); chk("done holds pattern", {24'd0, out_port}, 32'h0F);
      bus_write(2'd3, 32'h2);
      chk("irq cleared", {31'd0, irq}, 32'h0);
      rd(2'd3, r); chk("status after clear", r, 32'h0400);

      // rotate right every cycle, stop and restart
      bus_write(2'd0, 32'h01);
      bus_write(2'd2, 32'd0);
      bus_write(2'd1, 32'h0005);
      wait_cyc(1); chk("rotr step1", {24'd0, out_port}, 32'h80);
      wait_cyc(1); chk("rotr step2", {24'd0, out_port}, 32'h40);
      bus_write(2'd1, 32'h0004);
      chk("rotr frozen", {24'd0, out_port}, 32'h20);
      wait_cyc(3); chk("rotr frozen hold", {24'd0, out_port}, 32'h20);
      rd(2'd3, r); chk("stopped status", r, 32'h0300);
      bus_write(2'd1, 32'h0005);
      rd(2'd3, r); chk("restart status", r, 32'h0001);
      wait_cyc(1); chk("restart step1", {24'd0, out_port}, 32'h10);
      rd(2'd3, r); chk("restart step_cnt", r, 32'h0101);
      bus_write(2'd1, 32'h0000);

      // DATA write colliding with a step
      bus_write(2'd2, 32'd3);
      bus_write(2'd0, 32'h11);
      bus_write(2'd1, 32'h0003);
      repeat (2) @(posedge clk);
      bus_write(2'd0, 32'h55);
      chk("collide out", {24'd0, out_port}, 32'h55);
      rd(2'd3, r); chk("collide step_cnt", r, 32'h0101);
      wait_cyc(4); chk("collide next step", {24'd0, out_port}, 32'hAA);

      // asynchronous reset mid-run
      #1 reset_n = 1'b0;
      #1;
      chk("midrun reset out", {24'd0, out_port}, 32'h0);
      chk("midrun reset irq", {31'd0, irq}, 32'h0);
      rd(2'd3, r); chk("midrun reset status", r, 32'h0);
      rd(2'd1, r); chk("midrun reset ctrl", r, 32'h0);
      rd(2'd2, r); chk("midrun reset period", r, 32'h004C4B3F);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pio_pattern_sequencer.md
Name: pio_pattern_sequencer

Overview:
- Avalon-MM slave that drives an 8-bit parallel output, like the existing output PIO, and adds an autonomous sequencing engine.
- The CPU either writes a static value or programs a mode (rotate left, rotate right, blink), a step period and a step limit. The engine then steps the output pattern without CPU involvement.
- Sits on the system interconnect beside the other PIOs. Drives board LEDs. Raises an interrupt when a bounded sequence completes.

Parameters:
- DATA_WIDTH, 8, width of out_port and of the pattern/data registers.
- PERIOD_WIDTH, 24, width of the step-period register and counter.
- RESET_PERIOD, 24'd4999999, PERIOD value after reset.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe; a write occurs when chipselect && !write_n.
- writedata  input  32  write data.
- readdata  output  32  combinational read data for the current address, zero-extended; no read strobe, zero wait states.
- out_port  output  DATA_WIDTH  current pattern register.
- irq  output  1  done_flag && irq_en.

Behaviour:
- Clocking and reset: one clock, clk. Asynchronous active-low reset, reset_n. All flops clear on reset_n low regardless of clk.
- Reset values:
  - data_reg=0, pattern=0, so out_port=0.
  - ctrl=0: run=0, mode=0, irq_en=0, limit=0.
  - period=RESET_PERIOD, cnt=0, step_cnt=0, done_flag=0, irq=0.
  - FSM=IDLE.
- Register map (readdata):
  - addr0 DATA: [7:0] data_reg. Write sets data_reg and pattern on the same edge.
  - addr1 CTRL: [0] run, [2:1] mode (0 static, 1 rotl, 2 rotr, 3 blink), [3] irq_en, [15:8] limit. Readback returns the live run bit.
  - addr2 PERIOD: [PERIOD_WIDTH-1:0].
  - addr3 STATUS (read): [0] busy (FSM==RUN), [1] done_flag, [15:8] step_cnt. Write with writedata[1]=1 clears done_flag; other bits are ignored.
- FSM states: IDLE, RUN, DONE.
- IDLE: pattern holds.
  - CTRL write with run=1 and mode!=0: go to RUN next edge; cnt<=period; step_cnt<=0; done_flag<=0.
  - mode=0 with run=1: run bit stored, FSM stays IDLE (static output).
- RUN: cnt decrements each cycle. When cnt==0, on that edge:
  - pattern steps: rotl {p[6:0],p[7]}; rotr {p[0],p[7:1]}; blink p^data_reg.
  - step_cnt<=step_cnt+1, wrapping at 255.
  - cnt<=period.
  - Steps are therefore exactly period+1 cycles apart. The first step occurs period+1 cycles after the run write edge.
- Limit: if limit!=0 and the step makes step_cnt==limit, go to DONE on the same edge, run<=0, done_flag<=1. limit=0 means run indefinitely.
- Stop: CTRL write with run=0 in RUN goes to IDLE next edge. Pattern holds its current value; no done_flag.
- Restart: CTRL write with run=1 in RUN or DONE reloads cnt and clears step_cnt and done_flag. Enters RUN, or IDLE if mode=0. Mode and limit take effect immediately.
- DONE: pattern holds. Leave only by a CTRL write (run=1 restarts; run=0 goes to IDLE). done_flag stays until cleared via STATUS or by a restart.
- Simultaneous events:
  - DATA write on the same edge as a step: the bus value wins for pattern; step_cnt still increments.
  - STATUS clear on the same edge done_flag is set: the set wins.
- PERIOD write during RUN is used at the next reload; the current count is not disturbed. period=0 steps every cycle.
- Blink with data_reg=0 leaves the pattern constant; this is legal.
- Reset asserted mid-sequence forces all reset values immediately; out_port=0 asynchronously.

Test Plan:
- Reset: hold reset_n low mid-RUN -> out_port=0, irq=0, STATUS=0 immediately; CTRL reads 0; PERIOD reads RESET_PERIOD.
- Static: write DATA=0xA5 -> out_port=0xA5 on next edge; readdata at addr0=0x000000A5; CTRL run=1, mode=0 -> busy=0, out_port unchanged.
- Rotate left: DATA=0x81, PERIOD=3, CTRL=0x0003 (run, rotl, limit 0) -> out_port 0x03 at 4 cycles after the write, 0x06 at 8, 0x0C at 12; step_cnt=3.
- Bounded blink with irq: DATA=0x0F, PERIOD=1, CTRL=0x040F (run, blink, irq_en, limit 4) -> pattern 0x00,0x0F,0x00,0x0F every 2 cycles; then DONE, busy=0, done_flag=1, irq=1, CTRL[0]=0; write STATUS=0x2 -> irq=0.
- Stop and restart: rotr running from 0x01, PERIOD=0 -> 0x80, 0x40; write CTRL run=0 -> pattern frozen at its value; rewrite run=1 -> step_cnt=0, stepping resumes from the frozen value.
- Collision: with cnt==0 in RUN, write DATA=0x55 on the same edge -> out_port=0x55, step_cnt incremented; next step rotates 0x55.
